// File: rtl/decode_pkg.sv
// Shared opcode/funct constants, control codes and the decoded bundle type for the RV32I(M) decode stage.
package decode_pkg;

  localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL       = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR      = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD      = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE     = 7'b0100011;
  localparam logic [6:0] OPCODE_IMM_ARITH = 7'b0010011;
  localparam logic [6:0] OPCODE_ARITH     = 7'b0110011;
  localparam logic [6:0] OPCODE_FENCE     = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SR      = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Zero is reserved as "no operation" so an illegal entry carries no op.
  localparam logic [4:0] ALU_NONE   = 5'd0;
  localparam logic [4:0] ALU_ADD    = 5'd1;
  localparam logic [4:0] ALU_SUB    = 5'd2;
  localparam logic [4:0] ALU_SLL    = 5'd3;
  localparam logic [4:0] ALU_SLT    = 5'd4;
  localparam logic [4:0] ALU_SLTU   = 5'd5;
  localparam logic [4:0] ALU_XOR    = 5'd6;
  localparam logic [4:0] ALU_SRL    = 5'd7;
  localparam logic [4:0] ALU_SRA    = 5'd8;
  localparam logic [4:0] ALU_OR     = 5'd9;
  localparam logic [4:0] ALU_AND    = 5'd10;
  localparam logic [4:0] ALU_MUL    = 5'd11;
  localparam logic [4:0] ALU_MULH   = 5'd12;
  localparam logic [4:0] ALU_MULHSU = 5'd13;
  localparam logic [4:0] ALU_MULHU  = 5'd14;
  localparam logic [4:0] ALU_DIV    = 5'd15;
  localparam logic [4:0] ALU_DIVU   = 5'd16;
  localparam logic [4:0] ALU_REM    = 5'd17;
  localparam logic [4:0] ALU_REMU   = 5'd18;

  localparam logic [2:0] LSU_B  = 3'd0;
  localparam logic [2:0] LSU_H  = 3'd1;
  localparam logic [2:0] LSU_W  = 3'd2;
  localparam logic [2:0] LSU_BU = 3'd4;
  localparam logic [2:0] LSU_HU = 3'd5;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_JAL  = 3'd2;
  localparam logic [2:0] BR_JALR = 3'd3;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;

  localparam logic [1:0] RS2_RS1 = 2'd0;
  localparam logic [1:0] IMM_RS1 = 2'd1;
  localparam logic [1:0] IMM_PC  = 2'd2;

  localparam logic [1:0] DEST_ALU = 2'd0;
  localparam logic [1:0] DEST_MEM = 2'd1;
  localparam logic [1:0] DEST_PC  = 2'd2;

  typedef struct packed {
    logic        illegal;
    logic [31:0] pc;
    logic        br_sig;
    logic [2:0]  br_op;
    logic [2:0]  lsu_op;
    logic [4:0]  alu_op;
    logic [1:0]  data_origin;
    logic [1:0]  data_dest;
    logic [31:0] imm;
    logic [4:0]  reg_addr1;
    logic [4:0]  reg_addr2;
    logic [4:0]  reg_wr_addr;
    logic        reg_wr_sig;
    logic        mem_wr_sig;
  } decoded_t;

  // alt selects SUB/SRA over ADD/SRL for the shared funct3 slots.
  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      FUNCT3_ADD_SUB: alu_base = alt ? ALU_SUB : ALU_ADD;
      FUNCT3_SLL:     alu_base = ALU_SLL;
      FUNCT3_SLT:     alu_base = ALU_SLT;
      FUNCT3_SLTU:    alu_base = ALU_SLTU;
      FUNCT3_XOR:     alu_base = ALU_XOR;
      FUNCT3_SR:      alu_base = alt ? ALU_SRA : ALU_SRL;
      FUNCT3_OR:      alu_base = ALU_OR;
      default:        alu_base = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I(M) decoder with illegal-encoding detection.
// DECODE_RV32M_EN enables the M-extension ARITH encodings; otherwise they decode as illegal.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output decoded_t    dec
);

`ifdef DECODE_RV32M_EN
  localparam logic M_EN = 1'b1;
`else
  localparam logic M_EN = 1'b0;
`endif

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        illegal;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec     = '0;
    dec.pc  = pc;
    illegal = 1'b0;
    case (opcode)
      OPCODE_LUI: begin
        dec.alu_op = ALU_ADD; dec.data_origin = IMM_RS1; dec.imm = imm_u;
        dec.reg_wr_addr = rd; dec.reg_wr_sig = 1'b1;
      end
      OPCODE_AUIPC: begin
        dec.alu_op = ALU_ADD; dec.data_origin = IMM_PC; dec.imm = imm_u;
        dec.reg_wr_addr = rd; dec.reg_wr_sig = 1'b1;
      end
      OPCODE_JAL: begin
        dec.br_sig = 1'b1; dec.br_op = BR_JAL; dec.data_origin = IMM_PC;
        dec.data_dest = DEST_PC; dec.imm = imm_j;
        dec.reg_wr_addr = rd; dec.reg_wr_sig = 1'b1;
      end
      OPCODE_JALR: begin
        illegal = (f3 != 3'b000);
        dec.br_sig = 1'b1; dec.br_op = BR_JALR; dec.data_origin = IMM_RS1;
        dec.data_dest = DEST_PC; dec.imm = imm_i; dec.reg_addr1 = rs1;
        dec.reg_wr_addr = rd; dec.reg_wr_sig = 1'b1;
      end
      OPCODE_BRANCH: begin
        illegal = (f3 == 3'b010) || (f3 == 3'b011);
        dec.br_sig = 1'b1; dec.br_op = f3; dec.data_origin = RS2_RS1;
        dec.imm = imm_b; dec.reg_addr1 = rs1; dec.reg_addr2 = rs2;
      end
      OPCODE_LOAD: begin
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        dec.lsu_op = f3; dec.alu_op = ALU_ADD; dec.data_origin = IMM_RS1;
        dec.data_dest = DEST_MEM; dec.imm = imm_i; dec.reg_addr1 = rs1;
        dec.reg_wr_addr = rd; dec.reg_wr_sig = 1'b1;
      end
      OPCODE_STORE: begin
        illegal = (f3[2] == 1'b1) || (f3 == 3'b011);
        dec.lsu_op = f3; dec.alu_op = ALU_ADD; dec.data_origin = IMM_RS1;
        dec.imm = imm_s; dec.reg_addr1 = rs1; dec.reg_addr2 = rs2;
        dec.mem_wr_sig = 1'b1;
      end
      OPCODE_IMM_ARITH: begin
        dec.data_origin = IMM_RS1; dec.imm = imm_i; dec.reg_addr1 = rs1;
        dec.reg_wr_addr = rd; dec.reg_wr_sig = 1'b1;
        dec.alu_op = alu_base(f3, 1'b0);
        // Shift amounts live in imm[4:0]; the upper bits are the funct7 selector.
        if (f3 == FUNCT3_SLL) begin
          illegal = (f7 != FUNCT7_BASE);
          dec.imm = {27'b0, imm_i[4:0]};
        end else if (f3 == FUNCT3_SR) begin
          illegal = (f7 != FUNCT7_BASE) && (f7 != FUNCT7_ALT);
          dec.alu_op = alu_base(f3, f7 == FUNCT7_ALT);
          dec.imm = {27'b0, imm_i[4:0]};
        end
      end
      OPCODE_ARITH: begin
        dec.data_origin = RS2_RS1; dec.reg_addr1 = rs1; dec.reg_addr2 = rs2;
        dec.reg_wr_addr = rd; dec.reg_wr_sig = 1'b1;
        if (f7 == FUNCT7_BASE)
          dec.alu_op = alu_base(f3, 1'b0);
        else if (f7 == FUNCT7_ALT && (f3 == FUNCT3_ADD_SUB || f3 == FUNCT3_SR))
          dec.alu_op = alu_base(f3, 1'b1);
        else if (M_EN && f7 == FUNCT7_MULDIV)
          dec.alu_op = ALU_MUL + {2'b00, f3};
        else
          illegal = 1'b1;
      end
      OPCODE_FENCE, OPCODE_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
    if (dec.reg_wr_addr == 5'd0)
      dec.reg_wr_sig = 1'b0;
    // Illegal entries keep only their PC so a later trap can report it.
    if (illegal) begin
      dec         = '0;
      dec.pc      = pc;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode_comb feeding a DEPTH-entry FIFO with valid/ready on both sides.
// Build with DECODE_RV32M_EN defined to accept the M-extension encodings.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic            illegal_o,
  output logic            br_sig_o,
  output logic [2:0]      br_op_o,
  output logic [2:0]      lsu_op_o,
  output logic [4:0]      alu_op_o,
  output logic [1:0]      data_origin_o,
  output logic [1:0]      data_dest_o,
  output logic [31:0]     imm_o,
  output logic [4:0]      reg_addr1_o,
  output logic [4:0]      reg_addr2_o,
  output logic [4:0]      reg_wr_addr_o,
  output logic            reg_wr_sig_o,
  output logic            mem_wr_sig_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  decoded_t         dec, head;
  decoded_t         fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  decode_comb u_decode_comb (
    .instr (instr_i),
    .pc    (pc_i),
    .dec   (dec)
  );

  assign ready_o = (count != CNT_W'(DEPTH));
  assign valid_o = (count != '0);
  assign push    = valid_i && ready_o && !flush_i;
  assign pop     = valid_o && ready_i && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        fifo_mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= dec;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Stale slots may hold old entries, so the head is masked whenever the FIFO is empty.
  assign head = valid_o ? fifo_mem[rd_ptr] : '0;

  assign pc_o          = head.pc;
  assign illegal_o     = head.illegal;
  assign br_sig_o      = head.br_sig;
  assign br_op_o       = head.br_op;
  assign lsu_op_o      = head.lsu_op;
  assign alu_op_o      = head.alu_op;
  assign data_origin_o = head.data_origin;
  assign data_dest_o   = head.data_dest;
  assign imm_o         = head.imm;
  assign reg_addr1_o   = head.reg_addr1;
  assign reg_addr2_o   = head.reg_addr2;
  assign reg_wr_addr_o = head.reg_wr_addr;
  assign reg_wr_sig_o  = head.reg_wr_sig;
  assign mem_wr_sig_o  = head.mem_wr_sig;

endmodule
